// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and the queued writeback entry type.
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_G0 = 5'd0;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_bypass_lookup.sv
// rf_bypass_lookup: youngest-match forwarding of queued writes onto one read port.
module rf_bypass_lookup #(
  parameter int DEPTH = 4,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  entry_data,
  input  logic [DEPTH-1:0]              valid,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [DATA_W-1:0]             rf_data,
  output logic [DATA_W-1:0]             data
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [PTR_W-1:0] idx;
  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    data = rf_data;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && entry_addr[idx] == addr) data = entry_data[idx];
    end
    if (addr == ADDR_W'(rf_pkg::REG_G0)) data = '0;
  end
endmodule

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: in-order writeback FIFO feeding the register-file write port,
// with forwarding of queued values onto both read operands.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush,
  input  logic                     drain_en,
  output logic                     rf_ld,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  input  logic [DATA_W-1:0]        rf_pa,
  input  logic [DATA_W-1:0]        rf_pb,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [DEPTH-1:0][ADDR_W-1:0] q_addr;
  logic [DEPTH-1:0][DATA_W-1:0] q_data;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head, tail;
  logic empty, full, push, pop;
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  assign wb_ready = !reset && !flush && (!full || drain_en);
  assign rf_ld = !empty && drain_en && !flush;
  assign rf_addr = empty ? '0 : q_addr[head];
  assign rf_data = empty ? '0 : q_data[head];
  assign pop = rf_ld;
  // Writes to %g0 complete the handshake but never occupy a slot.
  assign push = wb_valid && wb_ready && wb_addr != ADDR_W'(rf_pkg::REG_G0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
    end else if (flush) begin
      head <= tail;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      valid <= (valid & ~(DEPTH'(pop) << head)) | (DEPTH'(push) << tail);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= wb_addr;
      q_data[tail] <= wb_data;
    end
  end
  rf_bypass_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_a (
    .addr(rd_addr_a), .entry_addr(q_addr), .entry_data(q_data), .valid(valid),
    .head(head), .rf_data(rf_pa), .data(op_a)
  );
  rf_bypass_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_b (
    .addr(rd_addr_b), .entry_addr(q_addr), .entry_data(q_data), .valid(valid),
    .head(head), .rf_data(rf_pb), .data(op_b)
  );
endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed and randomized checks against a queue-based model.
module tb_rf_writeback_queue;
  import rf_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, wb_valid = 0, flush = 0, drain_en = 0;
  logic [4:0] wb_addr = 0, rd_addr_a = 0, rd_addr_b = 0, rf_addr;
  logic [31:0] wb_data = 0, rf_pa = 0, rf_pb = 0, rf_data, op_a, op_b;
  logic wb_ready, rf_ld;
  logic [2:0] count;
  int compared = 0, mismatched = 0;
  wb_entry_t q[$];
  logic [31:0] regs [32];

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .drain_en(drain_en),
    .rf_ld(rf_ld), .rf_addr(rf_addr), .rf_data(rf_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rf_pa(rf_pa), .rf_pb(rf_pb),
    .op_a(op_a), .op_b(op_b), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Youngest queued write to the address wins; %g0 always reads zero.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] r);
    fwd = r;
    foreach (q[i]) if (q[i].addr == a) fwd = q[i].data;
    if (a == 0) fwd = 0;
  endfunction

  // Inputs are set just after a rising edge; check mid-cycle, then advance the model.
  task automatic cyc();
    bit er, el;
    wb_entry_t hd;
    #3;
    er = !reset && !flush && (q.size() < DEPTH || drain_en);
    el = !reset && q.size() != 0 && drain_en && !flush;
    hd = (!reset && q.size() != 0) ? q[0] : '0;
    chk("wb_ready", 32'(wb_ready), 32'(er));
    chk("rf_ld", 32'(rf_ld), 32'(el));
    chk("rf_addr", 32'(rf_addr), 32'(hd.addr));
    chk("rf_data", rf_data, hd.data);
    chk("op_a", op_a, fwd(rd_addr_a, rf_pa));
    chk("op_b", op_b, fwd(rd_addr_b, rf_pb));
    chk("count", 32'(count), 32'(q.size()));
    @(posedge clk);
    if (reset || flush) q.delete();
    else begin
      if (el) begin
        regs[q[0].addr] = q[0].data;
        void'(q.pop_front());
      end
      if (wb_valid && er && wb_addr != 0) q.push_back('{addr: wb_addr, data: wb_data});
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [4:0] a, input logic [31:0] d, input bit de, input bit fl);
    wb_valid = v; wb_addr = a; wb_data = d; drain_en = de; flush = fl;
    cyc();
  endtask

  initial begin
    foreach (regs[i]) regs[i] = 0;
    rd_addr_a = 3; rf_pa = 32'h77; rd_addr_b = 0; rf_pb = 32'h99;
    @(posedge clk); #1;
    cyc();
    cyc();
    reset = 0;
    // single write with drain enabled: visible next cycle, then gone
    drive(1, 5, 32'hDEADBEEF, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    // fill to full, then accept a fifth while draining
    drive(1, 3, 32'h11, 0, 0);
    drive(1, 3, 32'h22, 0, 0);
    drive(1, 3, 32'h33, 0, 0);
    drive(1, 3, 32'h44, 0, 0);
    rd_addr_a = 3; rf_pa = 0;
    drive(1, 3, 32'h55, 0, 0);
    drive(1, 3, 32'h55, 1, 0);
    repeat (6) drive(0, 0, 0, 1, 0);
    // youngest-match forwarding
    drive(1, 7, 32'hA, 0, 0);
    drive(1, 7, 32'hB, 0, 0);
    rd_addr_a = 7; rf_pa = 0; rd_addr_b = 9; rf_pb = 32'h55;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    // %g0 writes are accepted and dropped
    rd_addr_a = 0; rf_pa = 32'h1234;
    drive(1, 0, 32'hFFFFFFFF, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    // flush with a competing push
    drive(1, 1, 32'h101, 0, 0);
    drive(1, 2, 32'h102, 0, 0);
    drive(1, 4, 32'h104, 0, 0);
    rd_addr_a = 2; rf_pa = 32'hAAAA; rd_addr_b = 4; rf_pb = 32'hBBBB;
    drive(1, 6, 32'h106, 1, 1);
    drive(0, 0, 0, 0, 0);
    // asynchronous reset in the middle of a drain
    drive(1, 8, 32'h208, 0, 0);
    drive(1, 9, 32'h209, 0, 0);
    wb_valid = 0; drain_en = 1;
    #1 chk("pre_reset_ld", 32'(rf_ld), 32'd1);
    #1 reset = 1;
    #1 chk("async_ld", 32'(rf_ld), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_ready", 32'(wb_ready), 32'd0);
    q.delete();
    @(posedge clk); #1;
    reset = 0;
    repeat (3) drive(0, 0, 0, 1, 0);
    // randomized traffic, read ports fed from the modeled register file
    for (int n = 0; n < 400; n++) begin
      rd_addr_a = 5'($urandom_range(0, 7));
      rd_addr_b = 5'($urandom_range(0, 7));
      rf_pa = regs[rd_addr_a];
      rf_pb = regs[rd_addr_b];
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Writeback buffer directly upstream of the 32x32 register file write port.
- Accepts completed results (destination register plus 32-bit value) from the execute stage over a valid/ready handshake and queues them in an in-order FIFO.
- Drains one entry per enabled cycle into the register file's load, decoder-select and data inputs.
- Forwards queued, not-yet-written values onto both read operands so consumers never see stale register contents; register 0 (%g0) is treated as hardwired zero.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2)
- DATA_W, 32, result/register width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  execute stage presents a result
- wb_ready  out  1  queue can accept this cycle
- wb_addr  in  ADDR_W  destination register of the result
- wb_data  in  DATA_W  result value
- flush  in  1  discard all queued entries (trap/annul)
- drain_en  in  1  write port granted this cycle
- rf_ld  out  1  drives register-file load enable
- rf_addr  out  ADDR_W  drives register-file write decoder select
- rf_data  out  DATA_W  drives register-file write data
- rd_addr_a  in  ADDR_W  read address on port A (same value sent to register file)
- rd_addr_b  in  ADDR_W  read address on port B
- rf_pa  in  DATA_W  raw register-file port A data
- rf_pb  in  DATA_W  raw register-file port B data
- op_a  out  DATA_W  bypassed operand A
- op_b  out  DATA_W  bypassed operand B
- count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: asynchronous, active-high. Clears head/tail pointers, count=0, all entry valid bits=0. While reset is high: wb_ready=0, rf_ld=0, rf_addr=0, rf_data=0. op_a and op_b pass rf_pa and rf_pb, except address 0, which gives 0.
- State: circular buffer of DEPTH entries {addr, data}, plus head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- empty = (count==0); full = (count==DEPTH).
- Pop (combinational presentation): when !empty, rf_addr/rf_data = head entry and rf_ld = drain_en & !flush. When empty, rf_ld=0, rf_addr=0, rf_data=0.
- Pop (commit): on the rising edge with rf_ld=1, the register file captures the head and head advances.
- wb_ready = !full | drain_en (a full queue accepts when a pop happens the same edge). wb_ready is 0 during flush.
- Push: on an edge with wb_valid & wb_ready & !flush:
  - wb_addr!=0: write {wb_addr, wb_data} at tail; tail advances.
  - wb_addr==0: accepted (handshake completes) but discarded; no entry, count unchanged.
- Simultaneous push and pop: count unchanged; both pointers advance. When empty, a push is not visible on rf_* until the next cycle.
- Write latency: a result accepted at edge N into an empty queue is written to the register file at edge N+1 if drain_en is high in cycle N+1.
- Flush: synchronous. At the next edge count=0, head=tail, all valid bits cleared. During the flush cycle rf_ld=0 and no push is accepted.
- Bypass (combinational), for each port X in {a, b}:
  - rd_addr_X==0: op_X = 0.
  - Otherwise, if any valid entry matches rd_addr_X: op_X = data of the youngest matching entry (closest to tail).
  - Otherwise op_X = rf_X.
  - Entries being popped this cycle still participate (the register file is not yet updated).
  - The incoming wb_data is NOT forwarded in its acceptance cycle.
- Multiple queued writes to the same register are preserved in order; the final register-file value equals the youngest.
- count is registered and reflects the post-edge occupancy.

Decomposition:
- Shared package rf_pkg:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32, REG_G0=5'd0
  - typedef wb_entry_t {addr, data}
- One sub-module: rf_bypass_lookup. Combinational youngest-match search over the entry array for one read address, instantiated twice (ports A and B).

Test Plan:
- Reset, then push (addr 5, 0xDEADBEEF) with drain_en=1 -> next cycle rf_ld=1, rf_addr=5, rf_data=0xDEADBEEF; count 1->0 after that edge.
- drain_en=0, push addr 3 with 0x11, 0x22, 0x33, 0x44 -> count=4, wb_ready=0. Fifth push with drain_en=1 is accepted in the same cycle; writes drain in order 0x11..0x44 then the fifth.
- Queue holds addr 7=0xA, then addr 7=0xB, rd_addr_a=7, rf_pa=0x0 -> op_a=0xB; rd_addr_b=9, rf_pb=0x55 -> op_b=0x55.
- Push addr 0 with 0xFFFFFFFF -> wb_ready=1, count stays 0, rf_ld never asserts; rd_addr_a=0 -> op_a=0 even with rf_pa=0x1234.
- Three entries queued, flush=1 with wb_valid=1 -> that cycle rf_ld=0, wb_ready=0; next cycle count=0, bypass returns rf_pa/rf_pb.
- Assert reset asynchronously mid-drain with 2 entries -> rf_ld drops immediately, count=0, no further register-file writes after release.
